relm_div_seq: RTL and testbench

Self-timed iterative unsigned divider for the ReLM custom-instruction path. It sequences the normalize, init, radix-4 loop and mod steps in hardware, so software issues one request instead of a DIV/DIVINIT/DIVLOOP/DIVMOD opcode stream. It sits between the operand register read and the custom result writeback, with a valid/ready handshake on each side.

---
 rtl/relm_div_seq_pkg.sv | 25 ++
 rtl/relm_div_seq_step.sv | 47 ++++
 rtl/relm_div_seq.sv | 192 +++++++++++++++++++
 tb/tb_relm_div_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/relm_div_seq_pkg.sv
// relm_div_seq_pkg
//   Shared definitions for the sequenced unsigned divider.
//   Holds the 2-bit controller state encodings and a helper that turns a
//   divider width into the width of an MSB bit index.
package relm_div_seq_pkg;

  // Controller states. They live here so that the controller and any
  // debug or trace logic decode the state register the same way.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_LOOP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Number of bits needed to hold a bit index 0..width-1.
  // Used only on parameters at elaboration time, never on data.
  function automatic int idx_width(input int width);
    int w;
    w = 1;
    while ((1 << w) < width) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/relm_div_seq_step.sv
// relm_div_seq_step
//   Combinational radix-4 restoring-division step (two quotient bits).
//   Ports:
//     i_r    : partial remainder before the step
//     i_q    : quotient accumulated so far
//     i_dq   : divisor aligned to the current quotient bit (D << pos)
//     i_qbit : one-hot weight of the current quotient bit (1 << pos)
//     o_r    : partial remainder after the step
//     o_q    : quotient after the step
//     o_last : this step consumes the last quotient bit(s)
module relm_div_seq_step #(
  parameter int WD = 32
) (
  input  logic [WD-1:0] i_r,
  input  logic [WD-1:0] i_q,
  input  logic [WD-1:0] i_dq,
  input  logic [WD-1:0] i_qbit,
  output logic [WD-1:0] o_r,
  output logic [WD-1:0] o_q,
  output logic          o_last
);

  logic          w_ge_hi;
  logic [WD-1:0] w_r_hi;
  logic [WD-1:0] w_q_hi;
  logic [WD-1:0] w_dq_lo;
  logic          w_has_lo;
  logic          w_ge_lo;

  // Upper bit of the pair: weight i_qbit, aligned divisor i_dq.
  assign w_ge_hi = (i_r >= i_dq);
  assign w_r_hi  = w_ge_hi ? (i_r - i_dq) : i_r;
  assign w_q_hi  = w_ge_hi ? (i_q | i_qbit) : i_q;

  // Lower bit of the pair only exists while the weight is at least 2;
  // when the weight is 1 the pair degenerates to a single radix-2 step.
  assign w_dq_lo  = i_dq >> 1;
  assign w_has_lo = |i_qbit[WD-1:1];
  assign w_ge_lo  = w_has_lo && (w_r_hi >= w_dq_lo);

  assign o_r = w_ge_lo ? (w_r_hi - w_dq_lo) : w_r_hi;
  assign o_q = w_ge_lo ? (w_q_hi | (i_qbit >> 1)) : w_q_hi;

  // Nothing left once the weight shifted right by two would be zero.
  assign o_last = ~(|i_qbit[WD-1:2]);

endmodule

// File: rtl/relm_div_seq.sv
// relm_div_seq
//   Self-timed iterative unsigned divider: one request in, quotient and
//   remainder out, with the normalize / init / radix-4 loop / result steps
//   sequenced internally.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     in_valid_in     : request valid
//     in_ready_out    : ready for a request (IDLE only)
//     n_in, d_in      : dividend and divisor, sampled on accept
//     out_valid_out   : result valid (DONE only)
//     out_ready_in    : consumer accepts the result
//     q_out, r_out    : quotient and remainder, held while out_valid_out
//     busy_out        : a request is in flight (INIT, LOOP or DONE)
//   Divide by zero returns Q = all ones and R = N.
module relm_div_seq
  import relm_div_seq_pkg::*;
#(
  parameter int WD = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_in,
  output logic          in_ready_out,
  input  logic [WD-1:0] n_in,
  input  logic [WD-1:0] d_in,
  output logic          out_valid_out,
  input  logic          out_ready_in,
  output logic [WD-1:0] q_out,
  output logic [WD-1:0] r_out,
  output logic          busy_out
);

  localparam int IW = idx_width(WD);
  localparam logic [WD-1:0] ONE = WD'(1);

  logic [1:0]    r_state;
  logic [WD-1:0] r_n;
  logic [WD-1:0] r_d;
  logic [WD-1:0] r_q;
  logic [WD-1:0] r_r;
  logic [WD-1:0] r_dq;
  logic [WD-1:0] r_qbit;
  logic [WD-1:0] r_q_out;
  logic [WD-1:0] r_r_out;

  // ------------------------------------------------------------------
  // MSB index of N and D: smear every set bit downwards, keep the top
  // bit of the smear as a one-hot, then binary-encode the one-hot.
  // ------------------------------------------------------------------
  logic [WD-1:0]          w_smear_n;
  logic [WD-1:0]          w_smear_d;
  logic [WD-1:0]          w_oh_n;
  logic [WD-1:0]          w_oh_d;
  logic [IW-1:0][WD-1:0]  w_sel_n;
  logic [IW-1:0][WD-1:0]  w_sel_d;
  logic [IW-1:0]          w_mn;
  logic [IW-1:0]          w_md;

  for (genvar gi = 0; gi < WD; gi++) begin : g_smear
    assign w_smear_n[gi] = |r_n[WD-1:gi];
    assign w_smear_d[gi] = |r_d[WD-1:gi];
  end

  assign w_oh_n = w_smear_n & ~(w_smear_n >> 1);
  assign w_oh_d = w_smear_d & ~(w_smear_d >> 1);

  // Index bit gi is set when the one-hot sits at a position whose
  // binary value has bit gi set.
  for (genvar gi = 0; gi < IW; gi++) begin : g_enc
    for (genvar gj = 0; gj < WD; gj++) begin : g_pos
      if (((gj >> gi) % 2) == 1) begin : g_on
        assign w_sel_n[gi][gj] = w_oh_n[gj];
        assign w_sel_d[gi][gj] = w_oh_d[gj];
      end else begin : g_off
        assign w_sel_n[gi][gj] = 1'b0;
        assign w_sel_d[gi][gj] = 1'b0;
      end
    end
    assign w_mn[gi] = |w_sel_n[gi];
    assign w_md[gi] = |w_sel_d[gi];
  end

  // ------------------------------------------------------------------
  // INIT decisions
  // ------------------------------------------------------------------
  logic          w_d_zero;
  logic          w_trivial;
  logic [IW-1:0] w_k;
  logic [WD-1:0] w_qbit0;
  logic [WD-1:0] w_dq0;

  assign w_d_zero  = ~(|r_d);
  // N == 0 or N shorter than D: the quotient is zero and R = N.
  assign w_trivial = ~(|r_n) || (w_mn < w_md);
  assign w_k       = w_mn - w_md;
  assign w_qbit0   = ONE << w_k;
  // mD + k = mN < WD, so this shift never drops a set bit.
  assign w_dq0     = r_d << w_k;

  // ------------------------------------------------------------------
  // Radix-4 step datapath
  // ------------------------------------------------------------------
  logic [WD-1:0] w_r_step;
  logic [WD-1:0] w_q_step;
  logic          w_last;

  relm_div_seq_step #(
    .WD (WD)
  ) u_step (
    .i_r    (r_r),
    .i_q    (r_q),
    .i_dq   (r_dq),
    .i_qbit (r_qbit),
    .o_r    (w_r_step),
    .o_q    (w_q_step),
    .o_last (w_last)
  );

  // ------------------------------------------------------------------
  // Controller and datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_d     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dq    <= '0;
      r_qbit  <= '0;
      r_q_out <= '0;
      r_r_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid_in) begin
            r_n     <= n_in;
            r_d     <= d_in;
            r_state <= ST_INIT;
          end
        end

        ST_INIT: begin
          r_r <= r_n;
          if (w_d_zero) begin
            r_q     <= '1;
            r_q_out <= '1;
            r_r_out <= r_n;
            r_state <= ST_DONE;
          end else if (w_trivial) begin
            r_q     <= '0;
            r_q_out <= '0;
            r_r_out <= r_n;
            r_state <= ST_DONE;
          end else begin
            r_q     <= '0;
            r_dq    <= w_dq0;
            r_qbit  <= w_qbit0;
            r_state <= ST_LOOP;
          end
        end

        ST_LOOP: begin
          r_r    <= w_r_step;
          r_q    <= w_q_step;
          r_dq   <= r_dq >> 2;
          r_qbit <= r_qbit >> 2;
          // The result registers are loaded only on entry to DONE, so the
          // previous result stays visible while the next one is computed.
          if (w_last) begin
            r_q_out <= w_q_step;
            r_r_out <= w_r_step;
            r_state <= ST_DONE;
          end
        end

        default: begin // ST_DONE
          if (out_ready_in) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready_out  = (r_state == ST_IDLE);
  assign out_valid_out = (r_state == ST_DONE);
  assign busy_out      = (r_state != ST_IDLE);
  assign q_out         = r_q_out;
  assign r_out         = r_r_out;

endmodule

// File: tb/tb_relm_div_seq.sv
module tb_relm_div_seq;

  localparam int WD = 32;

  logic          clk;
  logic          rst;
  logic          in_valid_in;
  logic          in_ready_out;
  logic [WD-1:0] n_in;
  logic [WD-1:0] d_in;
  logic          out_valid_out;
  logic          out_ready_in;
  logic [WD-1:0] q_out;
  logic [WD-1:0] r_out;
  logic          busy_out;

  relm_div_seq #(.WD(WD)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (in_ready_out),
    .n_in          (n_in),
    .d_in          (d_in),
    .out_valid_out (out_valid_out),
    .out_ready_in  (out_ready_in),
    .q_out         (q_out),
    .r_out         (r_out),
    .busy_out      (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WD-1:0] n;
    logic [WD-1:0] d;
    logic [WD-1:0] q;
    logic [WD-1:0] r;
    int            lat;       // edges from accept edge to first valid cycle
    longint        acc_edge;
  } exp_t;

  exp_t   sb[$];
  exp_t   cur;
  bit     have_cur = 0;
  longint cyc = 0;
  longint retire_edge = 0;
  longint last_acc_edge = 0;
  int     acc_count = 0;
  int     ret_count = 0;
  int     errors = 0;
  int     checks = 0;
  bit     rand_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int msb_of(input logic [WD-1:0] x);
    for (int i = WD - 1; i >= 0; i--) begin
      if (x[i]) return i;
    end
    return -1;
  endfunction

  // Reference: plain division; latency from the MSB distance.
  function automatic exp_t model(input logic [WD-1:0] n, input logic [WD-1:0] d);
    exp_t e;
    int   k;
    e.n = n;
    e.d = d;
    e.acc_edge = 0;
    if (d == 0) begin
      e.q = '1;
      e.r = n;
      e.lat = 1;
    end else begin
      e.q = n / d;
      e.r = n % d;
      if (n == 0 || msb_of(n) < msb_of(d)) begin
        e.lat = 1;
      end else begin
        k = msb_of(n) - msb_of(d);
        e.lat = (k / 2 + 1) + 1;   // INIT edge + L loop edges
      end
    end
    return e;
  endfunction

  // Accept monitor: pushes the expected response when a request is taken.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_valid_in && in_ready_out) begin
      e = model(n_in, d_in);
      e.acc_edge = cyc + 1;
      sb.push_back(e);
      last_acc_edge = cyc + 1;
      acc_count++;
    end
  end

  // Result monitor: pops on first valid cycle, checks every valid cycle.
  always @(negedge clk) begin
    if (rst) begin
      have_cur = 0;
    end else if (out_valid_out) begin
      if (!have_cur) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'(out_valid_out), 64'd0);
        end else begin
          cur = sb.pop_front();
          have_cur = 1;
          chk("latency", 64'(cyc - cur.acc_edge), 64'(cur.lat));
          if (cur.d != 0) begin
            chk("inv_eq", 64'(q_out) * 64'(cur.d) + 64'(r_out), 64'(cur.n));
            chk("inv_rlt", 64'(r_out < cur.d), 64'd1);
          end
        end
      end
      if (have_cur) begin
        chk("q_out", 64'(q_out), 64'(cur.q));
        chk("r_out", 64'(r_out), 64'(cur.r));
        chk("ready_in_done", 64'(in_ready_out), 64'd0);
        chk("busy_in_done", 64'(busy_out), 64'd1);
        if (out_ready_in) begin
          retire_edge = cyc + 1;
          have_cur = 0;
          ret_count++;
          $display("txn %0d: N=0x%0h D=0x%0h -> Q=0x%0h R=0x%0h", ret_count, cur.n, cur.d, q_out, r_out);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) out_ready_in = ($urandom % 4) != 0;
  endtask

  task automatic send(input logic [WD-1:0] n, input logic [WD-1:0] d);
    int t;
    in_valid_in = 1'b1;
    n_in = n;
    d_in = d;
    t = 0;
    while (!in_ready_out && t < 500) begin
      tick();
      t++;
    end
    if (!in_ready_out) chk("send_timeout", 64'(in_ready_out), 64'd1);
    tick();
    in_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || have_cur || busy_out) && t < 1000) begin
      tick();
      t++;
    end
    if (t >= 1000) chk("idle_timeout", 64'(busy_out), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(in_ready_out), 64'd1);
    chk({tag, "_valid"}, 64'(out_valid_out), 64'd0);
    chk({tag, "_busy"}, 64'(busy_out), 64'd0);
    chk({tag, "_q"}, 64'(q_out), 64'd0);
    chk({tag, "_r"}, 64'(r_out), 64'd0);
  endtask

  initial begin
    int  acc_before;
    int  t;
    logic [WD-1:0] n;
    logic [WD-1:0] d;

    rst = 1'b1;
    in_valid_in = 1'b0;
    n_in = '0;
    d_in = '0;
    out_ready_in = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Directed corner cases
    send(32'd100, 32'd7);            wait_idle();
    send(32'd5, 32'd9);              wait_idle();
    send(32'd0, 32'd3);              wait_idle();
    send(32'h1234, 32'd0);           wait_idle();
    send(32'hFFFF_FFFF, 32'd1);      wait_idle();
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();

    // Backpressure: result held, no second accept while in DONE
    out_ready_in = 1'b0;
    send(32'd1000, 32'd3);
    t = 0;
    while (!out_valid_out && t < 100) begin
      tick();
      t++;
    end
    chk("bp_reach_done", 64'(out_valid_out), 64'd1);
    in_valid_in = 1'b1;
    n_in = 32'd77;
    d_in = 32'd5;
    acc_before = acc_count;
    repeat (5) begin
      tick();
      chk("bp_ready_low", 64'(in_ready_out), 64'd0);
      chk("bp_valid_held", 64'(out_valid_out), 64'd1);
    end
    chk("bp_no_accept", 64'(acc_count), 64'(acc_before));
    out_ready_in = 1'b1;
    tick();   // retire edge
    chk("bp_idle_after_retire", 64'(in_ready_out), 64'd1);
    tick();   // accept edge
    in_valid_in = 1'b0;
    chk("bp_second_accept", 64'(acc_count), 64'(acc_before + 1));
    chk("bp_accept_timing", 64'(last_acc_edge), 64'(retire_edge + 1));
    wait_idle();

    // Reset in the third LOOP cycle discards the in-flight result
    send(32'hFFFF_FFFF, 32'd1);      // now in INIT
    repeat (3) tick();               // now in third LOOP cycle
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    check_reset_outputs("midloop_reset");
    send(32'd100, 32'd7);            wait_idle();

    // Randomized traffic with random consumer backpressure
    rand_bp = 1;
    for (int i = 0; i < 3000; i++) begin
      n = $urandom >> $urandom_range(0, 31);
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 63) == 0) d = '0;
      send(n, d);
    end
    rand_bp = 0;
    out_ready_in = 1'b1;
    wait_idle();
    chk("all_retired", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
